// File: rtl/psum_out_pkg.sv
// rtl/psum_out_pkg.sv - shared FSM state and mode constants for the psum output stage
package psum_out_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_EMIT = 2'd2
    } state_t;

    localparam logic MODE_WS = 1'b0;
    localparam logic MODE_OS = 1'b1;

endpackage

// File: rtl/psum_col_fifo.sv
// rtl/psum_col_fifo.sv - single-column psum FIFO, extra pointer bit separates full from empty
module psum_col_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] rdata
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];
    logic         do_push;
    logic         do_pop;

    // a push into a full column is dropped even when a pop frees a slot this cycle
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/psum_out_stage.sv
// rtl/psum_out_stage.sv - per-column psum queues, WS accumulation with saturation, OS pass-through
module psum_out_stage
    import psum_out_pkg::*;
#(
    parameter int COL     = 8,
    parameter int PSUM_BW = 16,
    parameter int DEPTH   = 16,
    parameter int LEN_BW  = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   mode,
    input  logic                   relu_en,
    input  logic [LEN_BW-1:0]      acc_len,
    input  logic [COL-1:0]         in_valid,
    input  logic [COL*PSUM_BW-1:0] in_data,
    output logic [COL-1:0]         in_full,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [COL*PSUM_BW-1:0] out_data,
    output logic                   overflow_err,
    output logic                   busy
);

    state_t                 state, state_n;
    logic                   mode_q, mode_q_n;
    logic [LEN_BW-1:0]      target, target_n;
    logic [LEN_BW-1:0]      cnt, cnt_n;
    logic [LEN_BW:0]        cnt_inc;
    logic [LEN_BW-1:0]      target_new;
    logic [COL*PSUM_BW-1:0] acc, acc_n;
    logic [COL*PSUM_BW-1:0] acc_sum;
    logic [COL*PSUM_BW-1:0] row;
    logic [COL*PSUM_BW-1:0] emit_data;
    logic [COL-1:0]         col_empty;
    logic                   row_avail;
    logic                   pop;

    function automatic logic [PSUM_BW-1:0] sat_add(input logic [PSUM_BW-1:0] a,
                                                   input logic [PSUM_BW-1:0] b);
        logic [PSUM_BW:0] s;
        s = {a[PSUM_BW-1], a} + {b[PSUM_BW-1], b};
        if (s[PSUM_BW] != s[PSUM_BW-1])
            return s[PSUM_BW] ? {1'b1, {(PSUM_BW-1){1'b0}}} : {1'b0, {(PSUM_BW-1){1'b1}}};
        return s[PSUM_BW-1:0];
    endfunction

    genvar gc;
    generate
        for (gc = 0; gc < COL; gc++) begin : g_col
            psum_col_fifo #(
                .W     (PSUM_BW),
                .DEPTH (DEPTH)
            ) u_fifo (
                .clk   (clk),
                .reset (reset),
                .push  (in_valid[gc]),
                .pop   (pop),
                .wdata (in_data[gc*PSUM_BW +: PSUM_BW]),
                .full  (in_full[gc]),
                .empty (col_empty[gc]),
                .rdata (row[gc*PSUM_BW +: PSUM_BW])
            );
        end
    endgenerate

    assign row_avail  = ~|col_empty;
    assign cnt_inc    = {1'b0, cnt} + (LEN_BW+1)'(1);
    assign target_new = (mode == MODE_OS) ? LEN_BW'(1)
                      : ((acc_len == '0) ? LEN_BW'(1) : acc_len);

    always_comb begin
        acc_sum = '0;
        for (int c = 0; c < COL; c++)
            acc_sum[c*PSUM_BW +: PSUM_BW] = sat_add(acc[c*PSUM_BW +: PSUM_BW],
                                                    row[c*PSUM_BW +: PSUM_BW]);
    end

    always_comb begin
        state_n  = state;
        acc_n    = acc;
        cnt_n    = cnt;
        mode_q_n = mode_q;
        target_n = target;
        pop      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (row_avail) begin
                    pop      = 1'b1;
                    mode_q_n = mode;
                    target_n = target_new;
                    acc_n    = row;
                    cnt_n    = LEN_BW'(1);
                    state_n  = (target_new == LEN_BW'(1)) ? ST_EMIT : ST_ACC;
                end
            end
            ST_ACC: begin
                if (row_avail) begin
                    pop     = 1'b1;
                    acc_n   = acc_sum;
                    cnt_n   = cnt_inc[LEN_BW-1:0];
                    if (cnt_inc == {1'b0, target}) state_n = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (out_valid && out_ready) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // ReLU only ever applies to accumulated (WS) results
    always_comb begin
        emit_data = acc_n;
        if (mode_q_n == MODE_WS && relu_en) begin
            for (int c = 0; c < COL; c++)
                if (acc_n[c*PSUM_BW + PSUM_BW - 1]) emit_data[c*PSUM_BW +: PSUM_BW] = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            mode_q       <= MODE_WS;
            target       <= LEN_BW'(1);
            cnt          <= '0;
            acc          <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            busy         <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            state     <= state_n;
            mode_q    <= mode_q_n;
            target    <= target_n;
            cnt       <= cnt_n;
            acc       <= acc_n;
            out_valid <= (state_n == ST_EMIT);
            busy      <= (state_n != ST_IDLE);
            // captured once on entry so the row stays stable while the handshake stalls
            if (state_n == ST_EMIT && state != ST_EMIT) out_data <= emit_data;
            if (|(in_valid & in_full)) overflow_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_psum_out_stage.sv
// tb/tb_psum_out_stage.sv - directed self-checking bench for psum_out_stage
module tb_psum_out_stage;

    localparam int COL     = 8;
    localparam int PSUM_BW = 16;
    localparam int DEPTH   = 16;
    localparam int LEN_BW  = 6;
    localparam int DW      = COL*PSUM_BW;

    logic              clk = 1'b0;
    logic              reset;
    logic              mode;
    logic              relu_en;
    logic [LEN_BW-1:0] acc_len;
    logic [COL-1:0]    in_valid;
    logic [DW-1:0]     in_data;
    logic [COL-1:0]    in_full;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic              overflow_err;
    logic              busy;

    int n_cmp = 0;
    int n_err = 0;

    psum_out_stage #(
        .COL     (COL),
        .PSUM_BW (PSUM_BW),
        .DEPTH   (DEPTH),
        .LEN_BW  (LEN_BW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .mode         (mode),
        .relu_en      (relu_en),
        .acc_len      (acc_len),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_full      (in_full),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .overflow_err (overflow_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rep(input logic [PSUM_BW-1:0] v);
        return {COL{v}};
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [COL-1:0] mask, input logic [PSUM_BW-1:0] v);
        in_valid = mask;
        in_data  = rep(v);
        @(negedge clk);
        in_valid = '0;
        in_data  = '0;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 50 && !out_valid; i++) @(negedge clk);
        check(tag, DW'(out_valid), DW'(1));
    endtask

    task automatic accept();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_valid", DW'(out_valid), '0);
        check("rst_busy", DW'(busy), '0);
        check("rst_ovf", DW'(overflow_err), '0);
        check("rst_full", DW'(in_full), '0);
        check("rst_data", out_data, '0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset     = 1'b1;
        mode      = 1'b0;
        relu_en   = 1'b0;
        acc_len   = '0;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        do_reset();

        // WS, three-row accumulation
        acc_len = 6'd3;
        push('1, 16'd5);
        push('1, -16'sd2);
        push('1, 16'd7);
        wait_valid("ws3_valid");
        check("ws3_data", out_data, rep(16'd10));
        check("ws3_busy", DW'(busy), DW'(1));
        accept();
        check("ws3_valid_drop", DW'(out_valid), '0);
        check("ws3_busy_drop", DW'(busy), '0);

        // ReLU on and off
        acc_len = 6'd2;
        relu_en = 1'b1;
        push('1, -16'sd9);
        push('1, 16'd4);
        wait_valid("relu_valid");
        check("relu_on", out_data, '0);
        accept();
        relu_en = 1'b0;
        push('1, -16'sd9);
        push('1, 16'd4);
        wait_valid("norelu_valid");
        check("relu_off", out_data, rep(16'hFFFB));
        accept();

        // saturation both directions
        push('1, 16'd30000);
        push('1, 16'd10000);
        wait_valid("satp_valid");
        check("sat_pos", out_data, rep(16'h7FFF));
        accept();
        push('1, -16'sd30000);
        push('1, -16'sd10000);
        wait_valid("satn_valid");
        check("sat_neg", out_data, rep(16'h8000));
        accept();

        // OS pass-through with back-pressure; acc_len ignored in OS
        mode    = 1'b1;
        relu_en = 1'b1;
        acc_len = 6'd5;
        push('1, 16'd1);
        check("os_lat0", DW'(out_valid), '0);
        push('1, 16'd2);
        check("os_lat1", DW'(out_valid), DW'(1));
        push('1, 16'd3);
        push('1, -16'sd4);
        repeat (5) @(negedge clk);
        check("os_hold", out_data, rep(16'd1));
        for (int k = 1; k <= 4; k++) begin
            wait_valid("os_valid");
            check("os_order", out_data, (k == 4) ? rep(16'hFFFC) : rep(PSUM_BW'(k)));
            accept();
        end
        check("os_no_ovf", DW'(overflow_err), '0);
        check("os_idle", DW'(busy), '0);

        // column 0 overflow
        mode = 1'b0;
        for (int i = 0; i < 15; i++) push(8'h01, 16'd1);
        check("fill15", DW'(in_full), '0);
        push(8'h01, 16'd1);
        check("fill16", DW'(in_full), DW'(8'h01));
        check("fill16_ovf", DW'(overflow_err), '0);
        push(8'h01, 16'd1);
        check("fill17_ovf", DW'(overflow_err), DW'(1));
        repeat (3) @(negedge clk);
        check("ovf_sticky", DW'(overflow_err), DW'(1));
        check("ovf_nopop", DW'(busy), '0);
        do_reset();

        // lagging column, then reset mid-accumulation
        acc_len = 6'd2;
        push(8'hF7, 16'd6);
        repeat (4) @(negedge clk);
        check("lag_nopop", DW'(busy), '0);
        push(8'h08, 16'd6);
        @(negedge clk);
        check("lag_acc", DW'(busy), DW'(1));
        check("lag_novalid", DW'(out_valid), '0);
        do_reset();
        push('1, 16'd3);
        push('1, 16'd4);
        wait_valid("fresh_valid");
        check("fresh_sum", out_data, rep(16'd7));
        accept();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
